// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 16:1 selector: walks the enabled channels in ascending order, waits a
// settle time per channel, and captures one bit each. MUX_SCAN_CONT_EN restarts after handshake.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mask,
  input  logic        mux_out,
  input  logic        ready,
  output logic [3:0]  sel,
  output logic [15:0] data,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

`ifdef MUX_SCAN_CONT_EN
  localparam bit ContEn = 1'b1;
`else
  localparam bit ContEn = 1'b0;
`endif

  localparam logic [3:0] SettleLast = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_e      state_q;
  logic [3:0]  sel_q;
  logic [3:0]  cnt_q;
  logic [15:0] data_q;
  logic [15:0] mask_q;
  logic        valid_q;
  logic        busy_q;

  // {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [4:0] first_from(input logic [15:0] m, input logic [4:0] from);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (5'(i) >= from)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  logic        launch;
  logic [15:0] launch_mask;
  logic [4:0]  launch_ch;
  logic [4:0]  next_ch;
  state_e      chan_st;

  always_comb begin
    launch_mask = (state_q == StIdle) ? mask : mask_q;
    launch      = ((state_q == StIdle) && start) || (ContEn && (state_q == StDone) && ready);
    launch_ch   = first_from(launch_mask, 5'd0);
    next_ch     = first_from(mask_q, {1'b0, sel_q} + 5'd1);
    if (SETTLE == 0) begin
      chan_st = StSample;
    end else begin
      chan_st = StSettle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (launch) begin
      mask_q <= launch_mask;
      data_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      if (launch_ch[4]) begin
        sel_q   <= launch_ch[3:0];
        state_q <= chan_st;
        valid_q <= 1'b0;
      end else begin
        // Empty mask: the result is an all-zero word available immediately.
        sel_q   <= '0;
        state_q <= StDone;
        valid_q <= 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_q   <= '0;
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StSample: begin
          data_q[sel_q] <= mux_out;
          if (next_ch[4]) begin
            sel_q   <= next_ch[3:0];
            state_q <= chan_st;
          end else begin
            state_q <= StDone;
            valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sel   = sel_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized self-checking bench for mux_scan_ctrl; two instances cover settle times 2 and 0.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_v [2];
  logic [15:0] mask_v  [2];
  logic        ready_v [2];
  logic        mux_v   [2];
  logic [3:0]  sel_v   [2];
  logic [15:0] data_v  [2];
  logic        valid_v [2];
  logic        busy_v  [2];
  logic [15:0] pat_v   [2];

  int n_cmp  = 0;
  int n_fail = 0;

  // Downstream selector model: combinational in sel.
  assign mux_v[0] = pat_v[0][sel_v[0]];
  assign mux_v[1] = pat_v[1][sel_v[1]];

  mux_scan_ctrl #(.SETTLE(2)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mask(mask_v[0]), .mux_out(mux_v[0]),
    .ready(ready_v[0]), .sel(sel_v[0]), .data(data_v[0]), .valid(valid_v[0]), .busy(busy_v[0])
  );

  mux_scan_ctrl #(.SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mask(mask_v[1]), .mux_out(mux_v[1]),
    .ready(ready_v[1]), .sel(sel_v[1]), .data(data_v[1]), .valid(valid_v[1]), .busy(busy_v[1])
  );

  function automatic int settle_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int popcount16(input logic [15:0] m);
    int c = 0;
    for (int i = 0; i < 16; i++) if (m[i]) c++;
    return c;
  endfunction

  function automatic logic [3:0] last_chan(input logic [15:0] m);
    logic [3:0] hi = '0;
    for (int i = 0; i < 16; i++) if (m[i]) hi = 4'(i);
    return hi;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full scan on instance k: latency, visit order, result, DONE hold and handshake.
  task automatic do_scan(input int k, input logic [15:0] m, input logic [15:0] p,
                         input int hold, input string tag);
    int         lat_exp;
    int         n;
    bit         seen;
    logic [3:0] seq[$];
    logic [3:0] exp_seq[$];
    logic [4:0] got;
    logic [21:0] done_exp;

    lat_exp = 1 + popcount16(m) * (settle_of(k) + 1);
    for (int i = 0; i < 16; i++) if (m[i]) exp_seq.push_back(4'(i));
    done_exp = {1'b1, 1'b1, last_chan(m), m & p};

    @(negedge clk);
    pat_v[k]   = p;
    mask_v[k]  = m;
    start_v[k] = 1'b1;
    ready_v[k] = 1'b0;
    n    = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      start_v[k] = 1'b0;
      mask_v[k]  = 16'($urandom);
      if (valid_v[k]) seen = 1;
      else if (busy_v[k] && (seq.size() == 0 || seq[$] != sel_v[k])) seq.push_back(sel_v[k]);
    end
    check({tag, " latency"}, n, lat_exp);
    check({tag, " visits"}, seq.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      got = (i < seq.size()) ? {1'b0, seq[i]} : 5'h1f;
      check({tag, " visit order"}, got, {1'b0, exp_seq[i]});
    end
    check({tag, " done outputs"}, {valid_v[k], busy_v[k], sel_v[k], data_v[k]}, done_exp);

    // Consumer stalls; start pulses and mask changes must not disturb the result.
    for (int c = 0; c < hold; c++) begin
      ready_v[k] = 1'b0;
      start_v[k] = 1'($urandom);
      mask_v[k]  = 16'($urandom);
      @(negedge clk);
      check({tag, " hold"}, {valid_v[k], busy_v[k], sel_v[k], data_v[k]}, done_exp);
    end
    ready_v[k] = 1'b1;
    start_v[k] = 1'($urandom);
    @(negedge clk);
    start_v[k] = 1'b0;
    ready_v[k] = 1'b0;
    check({tag, " after handshake"}, {valid_v[k], busy_v[k], data_v[k]}, {2'b00, m & p});
    @(negedge clk);
    check({tag, " stays idle"}, {valid_v[k], busy_v[k]}, 2'b00);
  endtask

  initial begin
    int         n;
    logic [15:0] m;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0;
      mask_v[k]  = '0;
      ready_v[k] = 1'b0;
      pat_v[k]   = '0;
    end
    repeat (3) @(negedge clk);
    check("reset s2", {valid_v[0], busy_v[0], sel_v[0], data_v[0]}, 32'h0);
    check("reset s0", {valid_v[1], busy_v[1], sel_v[1], data_v[1]}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after release", {busy_v[0], busy_v[1]}, 2'b00);

    do_scan(0, 16'hFFFF, 16'hA5C3, 0, "full scan");
    do_scan(1, 16'h8001, 16'hFFFF, 0, "two ends");
    do_scan(0, 16'h0000, 16'hFFFF, 2, "empty mask s2");
    do_scan(1, 16'h0000, 16'h1234, 1, "empty mask s0");
    do_scan(0, 16'($urandom) | 16'h0100, 16'($urandom), 10, "done stall");

    for (int r = 0; r < 8; r++) begin
      m = 16'($urandom);
      if (r % 3 == 0) m = m & 16'($urandom) & 16'($urandom);
      do_scan(r % 2, m, 16'($urandom), int'($urandom_range(0, 3)), "random");
    end

    // Abort mid-scan once channel 5 has been sampled.
    @(negedge clk);
    pat_v[0]   = 16'($urandom);
    mask_v[0]  = 16'hFFFF;
    start_v[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start_v[0] = 1'b0;
      n++;
    end while (sel_v[0] != 4'd6 && n < 200);
    check("reached channel 6", {28'h0, sel_v[0]}, 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("async reset s2", {valid_v[0], busy_v[0], sel_v[0], data_v[0]}, 32'h0);
    check("async reset s0", {valid_v[1], busy_v[1], sel_v[1], data_v[1]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no partial result", {valid_v[0], busy_v[0], data_v[0]}, 32'h0);
    do_scan(0, 16'hFFFF, 16'h5A3C, 1, "after abort");
    do_scan(1, 16'h7FFE, 16'($urandom), 0, "after abort s0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE, default 2, number of wait cycles between a sel change and its sample (legal 0..15).
REQ-002 SHALL provide clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide start  input  1  request a scan; sampled only in IDLE.
REQ-005 SHALL provide mask  input  16  channel enable, bit i = channel i; latched on an accepted start.
REQ-006 SHALL provide mux_out  input  1  output of the downstream 16:1 selector, combinational in sel.
REQ-007 SHALL provide sel  output  4  channel select driven to the 16:1 selector.
REQ-008 SHALL provide data  output  16  captured word, bit i = sample of channel i.
REQ-009 SHALL provide valid  output  1  data holds a complete scan result.
REQ-010 SHALL provide ready  input  1  consumer accepts data when valid && ready.
REQ-011 SHALL provide busy  output  1  high whenever state != IDLE.

Function
REQ-012 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-013 IDLE + start: SHALL latch mask, clear data to 0, go to SETTLE (or SAMPLE if SETTLE=0) with sel = lowest enabled channel; if mask == 0, go directly to DONE.
REQ-014 SETTLE: SHALL stay exactly SETTLE cycles, then go to SAMPLE; sel held constant.
REQ-015 SAMPLE: SHALL last one cycle; at its closing edge data[sel] <= mux_out.
REQ-016 After SAMPLE: SHALL move sel to the next higher enabled channel and re-enter SETTLE/SAMPLE, or go to DONE if none remains; disabled channels consume zero cycles.
REQ-017 Latency SHALL be exactly 1 + N*(SETTLE+1) cycles from start edge to valid rising, N = popcount(latched mask).
REQ-018 Bits of data for disabled channels SHALL read 0.
REQ-019 DONE: valid SHALL be 1 and data and sel SHALL be held stable until valid && ready.
REQ-020 On valid && ready in DONE: valid SHALL fall next edge and state SHALL return to IDLE (see REQ-026).
REQ-021 start while busy SHALL be ignored; changes to mask while busy SHALL have no effect.
REQ-022 start and a handshake in the same cycle SHALL complete the handshake only; start is not queued.
REQ-023 data SHALL change only during SAMPLE edges or on scan start; valid SHALL never be high outside DONE.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, sel 0, data 0, valid 0, busy 0, latched mask 0, settle counter 0.
REQ-025 Reset asserted mid-scan SHALL abort with no partial result presented; first start after release behaves as from power-up.

Configuration
REQ-026 Macro MUX_SCAN_CONT_EN: when defined, a handshake in DONE SHALL restart a scan with the latched mask (as REQ-013, data cleared) without start, and busy stays high; when undefined, DONE returns to IDLE and only start begins a scan.

Verification
REQ-027 SETTLE=2, mask 16'hFFFF, mux_out = bit[sel] of 16'hA5C3, ready=1 -> valid rises 49 cycles after start edge, data = 16'hA5C3, sel visits 0..15 in order.
REQ-028 SETTLE=0, mask 16'h8001, pattern 16'hFFFF -> sel 0 then 15, valid at cycle 3, data = 16'h8001.
REQ-029 mask 16'h0000 -> valid at cycle 1, data = 16'h0000, sel stays 0.
REQ-030 ready held 0 for 10 cycles in DONE, start pulsed and mask changed meanwhile -> data/valid/sel stable; after ready=1 one cycle later valid=0, busy=0 (macro undefined).
REQ-031 rst_n pulsed low mid-scan (after channel 5 sampled) -> all outputs 0 immediately; next start gives full correct result.
REQ-032 MUX_SCAN_CONT_EN defined, SETTLE=1, mask 16'h000F, ready=1 -> valid pulses every 9 cycles, busy never falls.
